// File: rtl/conv_pkg.sv
// Shared constants, counter sizing and FSM state encoding for the convolution
// weight-load path.
package conv_pkg;

    localparam int FSIZE   = 5;
    localparam int NWEIGHT = FSIZE * FSIZE;

    // Width of a counter that must hold the value n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int CNT_W = cnt_w(NWEIGHT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } wload_state_t;

endpackage

// File: rtl/conv_wload_if.sv
// Handshake and memory-side bundle for conv_wload; the bias field exists only
// when CONV_WLOAD_BIAS_EN is defined.
interface conv_wload_if #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 12
);
    logic              start;
    logic [AWIDTH-1:0] base_addr;
    logic              mem_re;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] read_data;
    logic              wreg_we;
    logic              busy;
    logic              done;
`ifdef CONV_WLOAD_BIAS_EN
    logic [DWIDTH-1:0] bias;

    modport master (
        output start, base_addr, read_data,
        input  mem_re, mem_addr, wreg_we, busy, done, bias
    );
    modport slave (
        input  start, base_addr, read_data,
        output mem_re, mem_addr, wreg_we, busy, done, bias
    );
`else
    modport master (
        output start, base_addr, read_data,
        input  mem_re, mem_addr, wreg_we, busy, done
    );
    modport slave (
        input  start, base_addr, read_data,
        output mem_re, mem_addr, wreg_we, busy, done
    );
`endif
endinterface

// File: rtl/conv_vpipe.sv
// DEPTH-stage single-bit valid delay line with asynchronous clear.
module conv_vpipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic vin,
    output logic vout,
    output logic empty
);
    logic [DEPTH-1:0] pipe;

    // empty ignores the output stage: the owner's DONE state is registered,
    // so it must leave DRAIN while the last valid is still being presented.
    if (DEPTH == 1) begin : g_one
        always_ff @(posedge clk or posedge rst) begin
            if (rst) pipe <= '0;
            else     pipe <= vin;
        end
        assign empty = 1'b1;
    end else begin : g_many
        always_ff @(posedge clk or posedge rst) begin
            if (rst) pipe <= '0;
            else     pipe <= {pipe[DEPTH-2:0], vin};
        end
        assign empty = ~|pipe[DEPTH-2:0];
    end

    assign vout = pipe[DEPTH-1];

endmodule

// File: rtl/conv_wload.sv
// Weight-load sequencer: reads one FSIZE x FSIZE filter and strobes wreg_we in
// step with returned data. Define CONV_WLOAD_BIAS_EN to also fetch a bias word.
//
// state   | meaning
// IDLE    | waiting for start; base latched on accept
// ISSUE   | mem_re high, address = base + count
// DRAIN   | reads in flight, waiting for valid pipe to empty
// DONE    | one-cycle done pulse
module conv_wload #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 12,
    parameter int FSIZE  = 5,
    parameter int RDLAT  = 1
) (
    input logic         clk,
    input logic         rst,
    conv_wload_if.slave bus
);
    import conv_pkg::*;

`ifdef CONV_WLOAD_BIAS_EN
    localparam int NLOAD = FSIZE * FSIZE + 1;
`else
    localparam int NLOAD = FSIZE * FSIZE;
`endif
    localparam int CW = cnt_w(NLOAD);

    wload_state_t      state, state_nxt;
    logic [AWIDTH-1:0] base_q;
    logic [CW-1:0]     count;
    logic              last_rd;
    logic              we_out;
    logic              drained;
    logic              busy_q;
    logic              done_q;

    assign bus.mem_re   = (state == S_ISSUE);
    assign bus.mem_addr = bus.mem_re ? base_q + AWIDTH'(count) : '0;
    assign last_rd      = bus.mem_re && (count == CW'(NLOAD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            base_q <= '0;
            count  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt != S_IDLE);
            done_q <= (state_nxt == S_DONE);
            if (state == S_IDLE && bus.start) begin
                base_q <= bus.base_addr;
                count  <= '0;
            end else if (bus.mem_re && !last_rd) begin
                count <= count + CW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (bus.start) state_nxt = S_ISSUE;
            S_ISSUE: if (last_rd)   state_nxt = S_DRAIN;
            S_DRAIN: if (drained)   state_nxt = S_DONE;
            S_DONE:                 state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

`ifdef CONV_WLOAD_BIAS_EN
    logic              bias_vld;
    logic              we_empty;
    logic              bias_empty;
    logic [DWIDTH-1:0] bias_q;

    // The bias read travels in its own pipe so it never reaches wreg_we.
    conv_vpipe #(.DEPTH(RDLAT)) u_we_pipe (
        .clk   (clk),
        .rst   (rst),
        .vin   (bus.mem_re && !last_rd),
        .vout  (we_out),
        .empty (we_empty)
    );
    conv_vpipe #(.DEPTH(RDLAT)) u_bias_pipe (
        .clk   (clk),
        .rst   (rst),
        .vin   (last_rd),
        .vout  (bias_vld),
        .empty (bias_empty)
    );
    assign drained = we_empty && bias_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           bias_q <= '0;
        else if (bias_vld) bias_q <= bus.read_data;
    end
    assign bus.bias = bias_q;
`else
    conv_vpipe #(.DEPTH(RDLAT)) u_we_pipe (
        .clk   (clk),
        .rst   (rst),
        .vin   (bus.mem_re),
        .vout  (we_out),
        .empty (drained)
    );
`endif

    assign bus.wreg_we = we_out;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: doc/conv_wload.md
# conv_wload

Weight-load sequencer for the convolution datapath. On a start pulse it reads one 5×5 filter (25 words) from weight memory at consecutive addresses from a latched base. It then pulses `wreg_we` in exact alignment with each returned `read_data` word, so the downstream 25-entry weight shift register ends up holding word k at `weight k`. It sits between the weight RAM and the weight shift register, under control of the layer controller.

## Interface
- `DWIDTH`, 16, data word width (matches the weight shift register)
- `AWIDTH`, 12, weight-memory address width
- `FSIZE`, 5, filter edge; `FSIZE*FSIZE` words are loaded per filter
- `RDLAT`, 1, weight-memory read latency in cycles, from `mem_re` to valid `read_data`; legal range ≥1

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset; asynchronous and active-high
- `start`  in  1  one-cycle request; sampled only in IDLE
- `base_addr`  in  AWIDTH  filter base address; latched on an accepted `start`
- `mem_re`  out  1  weight-memory read enable
- `mem_addr`  out  AWIDTH  weight-memory read address
- `read_data`  in  DWIDTH  memory read data; sampled only under `CONV_WLOAD_BIAS_EN`, otherwise routed past this block to the shift register
- `wreg_we`  out  1  shift-enable to the weight shift register
- `busy`  out  1  load in progress
- `done`  out  1  one-cycle completion pulse
- `bias`  out  DWIDTH  present only under `CONV_WLOAD_BIAS_EN`

## Operation
- States: IDLE → ISSUE → DRAIN → DONE → IDLE.
- IDLE:
  - `start`=1 latches `base_addr`, clears the read counter and moves to ISSUE.
  - `start`=0 stays in IDLE.
- ISSUE:
  - `mem_re`=1 every cycle.
  - `mem_addr` = latched base + count; count runs 0..N−1, with N=`FSIZE*FSIZE` (+1 with bias).
  - Address arithmetic is modulo 2^AWIDTH; wrap past the top of memory is silent.
  - After the cycle with count N−1, the FSM moves to DRAIN.
- DRAIN:
  - Waits until the read-valid pipe is empty.
  - The pipe is `mem_re` delayed RDLAT cycles.
- DONE:
  - `done`=1 for one cycle, then the FSM returns to IDLE.
- `wreg_we` is the RDLAT-delayed `mem_re`. It is high for exactly 25 cycles per load, and those 25 cycles are contiguous.
- `busy`=1 in ISSUE, DRAIN and DONE.
- `start` outside IDLE is ignored. It is neither queued nor used to restart the load.
- Reset, at any time including mid-load:
  - state IDLE; read pipe cleared.
  - `mem_re`, `wreg_we`, `busy` and `done` all 0.
  - `mem_addr`=0; `bias`=0.
  - A partial load is abandoned. The shift register holds whatever was shifted in, and the controller must reload it.

## Timing
- `start` is accepted at edge t:
  - `mem_re` is high in cycles t+1 … t+N, with addresses base … base+N−1.
  - `wreg_we` is high in cycles t+1+RDLAT … t+25+RDLAT.
  - `done` is high in cycle t+N+RDLAT+1.
- `busy` rises in cycle t+1 and falls after the `done` cycle.
- Back-to-back loads: the earliest next accepted `start` is in the cycle after `done`.
- All outputs are registered, except `mem_re`/`mem_addr`, which are decoded directly from state and count registers (no input-to-output combinational path).

## Configuration
- `CONV_WLOAD_BIAS_EN` defined:
  - N=26; the 26th word (address base+25) is the filter bias.
  - On its valid cycle, `wreg_we` stays 0 and `read_data` is captured into the `bias` register.
  - `bias` holds that value until the next load's bias capture or reset.
- `CONV_WLOAD_BIAS_EN` undefined:
  - N=25; no `bias` port or register.
  - `read_data` is unused inside the block.

## Structure
- Shared package `conv_pkg`:
  - `FSIZE`
  - `NWEIGHT` = `FSIZE*FSIZE`
  - the FSM state encoding (IDLE/ISSUE/DRAIN/DONE)
  - the counter width `$clog2(NWEIGHT+1)`
- Sub-module `conv_vpipe`: parameterised RDLAT-deep single-bit valid delay line with async active-high clear. It produces the delayed valid, and its "pipe empty" flag drives the DRAIN exit.

## Test plan
- Basic load, RDLAT=1, base=0x040, memory word at address a = a:
  - `mem_addr` 0x040..0x058 over 25 cycles.
  - `wreg_we` is 25 contiguous cycles starting one cycle later.
  - The shift register ends with `weight0`=0x040 and `weight24`=0x058.
  - `done` in cycle t+27.
- RDLAT=3, same stimulus: `wreg_we` window shifted by 3 cycles from `mem_re`; `done` in cycle t+29; exactly 25 shifts.
- Address wrap, base=0xFF0 with AWIDTH=12: addresses run 0xFF0..0xFFF, then 0x000..0x008.
- `start` pulsed during ISSUE and during DONE: ignored, with no extra `mem_re`. `start` in the cycle after `done` launches a second load.
- `rst` asserted at count 10 of ISSUE:
  - Outputs go to their reset values immediately (asynchronous reset).
  - No `wreg_we` pulses follow reset, even ones still in the pipe.
  - A subsequent start performs a full 25-word load.
- `CONV_WLOAD_BIAS_EN` build, word at base+25 = 0x1234: exactly 25 `wreg_we` pulses, `bias`=0x1234 after the load, and `done` in cycle t+28 (RDLAT=1).
